ahb_rr_master_arb: RTL and testbench



---
 rtl/ahb_rr_master_arb.sv | 195 +++++++++++++++++++
 tb/tb_ahb_rr_master_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_rr_master_arb.sv
// ahb_rr_master_arb: round-robin arbiter and single-beat transfer sequencer
// that shares one AHB-lite master port between NUM_REQ requesters.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_valid/req_ready            per-requester command handshake (ready is one-hot)
//   req_write/req_addr/req_wdata/req_size  flattened per-requester command fields
//   rsp_valid/rsp_rdata/rsp_err    one-hot completion pulse with read data and error
//   haddr/htrans/hwrite/hsize/hburst/hwdata  AHB-lite master outputs
//   hrdata/hready/hresp            AHB-lite master inputs
module ahb_rr_master_arb #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    input  logic [NUM_REQ*3-1:0]  req_size,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic [AW-1:0]         haddr,
    output logic [1:0]            htrans,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [2:0]            hburst,
    output logic [DW-1:0]         hwdata,
    input  logic [DW-1:0]         hrdata,
    input  logic                  hready,
    input  logic                  hresp
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_RESP} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic                 arb_en_q;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [AW-1:0]        haddr_q, haddr_d;
    logic [1:0]           htrans_q, htrans_d;
    logic                 hwrite_q, hwrite_d;
    logic [2:0]           hsize_q, hsize_d;
    logic [DW-1:0]        hwdata_q, hwdata_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]        rsp_rdata_q, rsp_rdata_d;
    logic                 rsp_err_q, rsp_err_d;

    logic [PW-1:0]        grant_idx;
    logic                 grant_vld;
    logic                 accept;
    logic [AW-1:0]        sel_addr;
    logic [2:0]           sel_size;
    logic                 sel_legal;

    // Round-robin search: first valid requester above the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_vld && req_valid[PW'(idx)]) begin
                grant_vld = 1'b1;
                grant_idx = PW'(idx);
            end
        end
    end

    // arb_en_q keeps req_ready low while reset is asserted.
    assign accept    = arb_en_q && (state_q == ST_IDLE) && grant_vld;
    assign req_ready = {{(NUM_REQ-1){1'b0}}, accept} << grant_idx;

    assign sel_addr  = req_addr[grant_idx*AW +: AW];
    assign sel_size  = req_size[grant_idx*3 +: 3];
    assign sel_legal = (sel_size == 3'd0) ||
                       ((sel_size == 3'd1) && !sel_addr[0]) ||
                       ((sel_size == 3'd2) && (sel_addr[1:0] == 2'b00));

    // Transfer sequencer next-state and output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        wdata_d     = wdata_q;
        haddr_d     = haddr_q;
        htrans_d    = htrans_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    ptr_d    = grant_idx;
                    owner_d  = grant_idx;
                    wdata_d  = req_wdata[grant_idx*DW +: DW];
                    hwrite_d = req_write[grant_idx];
                    if (sel_legal) begin
                        haddr_d  = sel_addr;
                        hsize_d  = sel_size;
                        htrans_d = HTRANS_NONSEQ;
                        state_d  = ST_ADDR;
                    end else begin
                        // Illegal command completes with an error, no bus cycle.
                        rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx;
                        rsp_rdata_d = '0;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (hready) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = hwrite_q ? wdata_q : '0;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                // First cycle of a two-cycle ERROR has hready=0 and is skipped.
                if (hready) begin
                    rsp_valid_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
                    rsp_rdata_d = hwrite_q ? '0 : hrdata;
                    rsp_err_d   = hresp;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= PW'(NUM_REQ - 1);
            owner_q     <= '0;
            arb_en_q    <= 1'b0;
            wdata_q     <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'd0;
            hwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            arb_en_q    <= 1'b1;
            wdata_q     <= wdata_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign haddr     = haddr_q;
    assign htrans    = htrans_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = 3'b000;
    assign hwdata    = hwdata_q;

endmodule

// File: tb/tb_ahb_rr_master_arb.sv
// Self-checking bench for ahb_rr_master_arb: directed vector table, reset and
// round-robin sequences, then randomized traffic against a transaction model.
module tb_ahb_rr_master_arb;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N*3-1:0]  req_size;
    logic [31:0]     rsp_rdata, haddr, hwdata, hrdata;
    logic            rsp_err, hwrite, hready, hresp;
    logic [1:0]      htrans;
    logic [2:0]      hsize, hburst;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ahb_rr_master_arb #(.NUM_REQ(N), .AW(32), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
        .hresp(hresp)
    );

    typedef struct {
        int          idx;
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [31:0] hrdata;
        int          waits;
        logic        err;
        logic        exp_legal;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_cmd(input int i, input logic w, input logic [31:0] a,
                           input logic [2:0] s, input logic [31:0] d);
        req_write[i]         = w;
        req_addr[i*32 +: 32] = a;
        req_size[i*3 +: 3]   = s;
        req_wdata[i*32 +: 32] = d;
    endtask

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (((v >> ((ptr + k) % N)) & 3'b001) != 3'b000) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic is_legal(input logic [31:0] a, input logic [2:0] s);
        return (s <= 3'd2) && ((a % (32'd1 << s)) == 32'd0);
    endfunction

    // One isolated transfer from a single requester, every cycle checked.
    task automatic run_vec(input vec_t v);
        int last;
        set_cmd(v.idx, v.write, v.addr, v.size, v.wdata);
        req_valid = 3'(1 << v.idx);
        hready = 1'b1;
        hresp  = 1'b0;
        settle();
        chk("vec_accept", 32'(req_ready), 32'(1) << v.idx);
        chk("vec_htrans_at_accept", 32'(htrans), 32'd0);
        tick();
        req_valid = '0;
        settle();
        if (!v.exp_legal) begin
            chk("vec_illegal_rsp_valid", 32'(rsp_valid), 32'(1) << v.idx);
            chk("vec_illegal_rsp_err", 32'(rsp_err), 32'd1);
            chk("vec_illegal_htrans", 32'(htrans), 32'd0);
        end else begin
            chk("vec_addr_htrans", 32'(htrans), 32'd2);
            chk("vec_addr_haddr", haddr, v.addr);
            chk("vec_addr_hwrite", 32'(hwrite), 32'(v.write));
            chk("vec_addr_hsize", 32'(hsize), 32'(v.size));
            chk("vec_addr_no_rsp", 32'(rsp_valid), 32'd0);
            last = v.waits + (v.err ? 1 : 0);
            for (int c = 0; c <= last; c++) begin
                tick();
                hready = (c == last);
                hresp  = v.err && (c >= last - 1);
                hrdata = (c == last) ? v.hrdata : $urandom;
                settle();
                chk("vec_data_htrans", 32'(htrans), 32'd0);
                if (v.write) chk("vec_data_hwdata", hwdata, v.wdata);
                chk("vec_data_no_rsp", 32'(rsp_valid), 32'd0);
            end
            tick();
            hready = 1'b1;
            hresp  = 1'b0;
            settle();
            chk("vec_rsp_valid", 32'(rsp_valid), 32'(1) << v.idx);
            chk("vec_rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("vec_rsp_err", 32'(rsp_err), 32'(v.exp_err));
        end
        tick();
        settle();
        chk("vec_rsp_single_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        vec_t        vecs[8];
        int          grants, rsps, prev, w;
        int          m_ptr, m_owner;
        logic        m_busy, m_write, addr_ph, data_ph, rsp_due, m_err;
        logic        err_plan, err_first;
        logic [31:0] m_addr, m_wdata, m_rdata;
        logic [2:0]  m_size;
        logic [N-1:0] pend;
        logic        c_write[N];
        logic [31:0] c_addr[N], c_wdata[N];
        logic [2:0]  c_size[N];

        //          idx wr addr          size wdata         hrdata        wt err legal eerr erdata
        vecs[0] = '{0, 0, 32'h0000_0000, 3'd2, 32'h0,        32'hA5A5_0001, 0, 0, 1, 0, 32'hA5A5_0001};
        vecs[1] = '{1, 1, 32'h0000_0004, 3'd2, 32'h1234_5678, 32'hFFFF_FFFF, 3, 0, 1, 0, 32'h0};
        vecs[2] = '{2, 1, 32'h0000_0010, 3'd2, 32'h0BAD_F00D, 32'h1111_1111, 0, 1, 1, 1, 32'h0};
        vecs[3] = '{0, 0, 32'h0000_0002, 3'd2, 32'h0,        32'h0,         0, 0, 0, 1, 32'h0};
        vecs[4] = '{1, 0, 32'h0000_0000, 3'd3, 32'h0,        32'h0,         0, 0, 0, 1, 32'h0};
        vecs[5] = '{2, 1, 32'h0000_0021, 3'd1, 32'h5555_AAAA, 32'h0,         0, 0, 0, 1, 32'h0};
        vecs[6] = '{2, 0, 32'h0000_0022, 3'd1, 32'h0,        32'h0000_BEEF, 1, 0, 1, 0, 32'h0000_BEEF};
        vecs[7] = '{1, 0, 32'h0000_0033, 3'd0, 32'h0,        32'h0000_0077, 2, 1, 1, 1, 32'h0000_0077};

        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_size = '0;
        hrdata = '0; hready = 1'b1; hresp = 1'b0;
        tick();
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_htrans", 32'(htrans), 32'd0);
        chk("reset_haddr", haddr, 32'd0);
        chk("reset_hburst", 32'(hburst), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset during the address phase drops the transfer.
        set_cmd(2, 1'b1, 32'h0000_0040, 3'd2, 32'hCAFE_0002);
        req_valid = 3'b100;
        settle();
        chk("mid_rst_accept", 32'(req_ready), 32'b100);
        tick();
        req_valid = '0;
        settle();
        chk("mid_rst_in_addr", 32'(htrans), 32'd2);
        rst_n = 1'b0;
        settle();
        chk("mid_rst_htrans", 32'(htrans), 32'd0);
        chk("mid_rst_haddr", haddr, 32'd0);
        chk("mid_rst_hwrite", 32'(hwrite), 32'd0);
        chk("mid_rst_hsize", 32'(hsize), 32'd0);
        chk("mid_rst_hwdata", hwdata, 32'd0);
        chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 32'h100 + 32'(i * 4), 3'd2, 32'h0);
        req_valid = 3'b111;
        settle();
        chk("mid_rst_ready_held_low", 32'(req_ready), 32'd0);
        chk("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        rst_n = 1'b1;

        // All three requesting continuously: strict rotation starting at 0.
        grants = 0; rsps = 0; prev = -1;
        for (int cyc = 0; cyc < 200 && rsps < 12; cyc++) begin
            tick();
            req_valid = (grants < 12) ? 3'b111 : 3'b000;
            hready = 1'b1;
            hresp  = 1'b0;
            hrdata = $urandom;
            settle();
            if (req_ready != '0) begin
                w = -1;
                for (int i = 0; i < N; i++) if (req_ready == 3'(1 << i)) w = i;
                chk("rr_order", 32'(w), 32'(grants % N));
                if (prev >= 0) chk("rr_no_repeat", 32'(w == prev), 32'd0);
                prev = w;
                grants++;
            end
            if (rsp_valid != '0) rsps++;
        end
        chk("rr_completed", 32'(rsps), 32'd12);

        // Randomized traffic against a transaction-level model.
        m_ptr = 2; m_owner = 0; m_busy = 0; addr_ph = 0; data_ph = 0; rsp_due = 0;
        m_err = 0; m_write = 0; m_addr = 0; m_wdata = 0; m_rdata = 0; m_size = 0;
        err_plan = 0; err_first = 0; pend = '0;
        for (int i = 0; i < N; i++) begin
            c_write[i] = 0; c_addr[i] = 0; c_wdata[i] = 0; c_size[i] = 0;
        end
        for (int cyc = 0; cyc < 1500; cyc++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 4 == 0)) begin
                    c_write[i] = 1'($urandom % 2);
                    c_size[i]  = ($urandom % 10 == 0) ? 3'd3 : 3'($urandom % 3);
                    c_addr[i]  = $urandom;
                    if ($urandom % 8 != 0) c_addr[i] = c_addr[i] & ~((32'd1 << c_size[i]) - 32'd1);
                    c_wdata[i] = $urandom;
                    set_cmd(i, c_write[i], c_addr[i], c_size[i], c_wdata[i]);
                    pend[i] = 1'b1;
                end
            end
            req_valid = pend;
            hrdata = $urandom;
            if (data_ph) begin
                if (err_first) begin hready = 1'b1; hresp = 1'b1; end
                else if ($urandom % 3 == 0) begin hready = 1'b0; hresp = 1'b0; end
                else if (err_plan) begin hready = 1'b0; hresp = 1'b1; err_first = 1'b1; end
                else begin hready = 1'b1; hresp = 1'b0; end
            end else begin
                hready = ($urandom % 4 != 0);
                hresp  = 1'b0;
            end
            settle();
            w = (!m_busy && pend != '0) ? rr_pick(m_ptr, pend) : -1;
            chk("rnd_req_ready", 32'(req_ready), (w >= 0) ? (32'(1) << w) : 32'd0);
            chk("rnd_rsp_valid", 32'(rsp_valid), rsp_due ? (32'(1) << m_owner) : 32'd0);
            if (rsp_due) begin
                chk("rnd_rsp_rdata", rsp_rdata, m_rdata);
                chk("rnd_rsp_err", 32'(rsp_err), 32'(m_err));
            end
            chk("rnd_htrans", 32'(htrans), addr_ph ? 32'd2 : 32'd0);
            if (addr_ph) begin
                chk("rnd_haddr", haddr, m_addr);
                chk("rnd_hwrite", 32'(hwrite), 32'(m_write));
                chk("rnd_hsize", 32'(hsize), 32'(m_size));
            end
            if (data_ph && m_write) chk("rnd_hwdata", hwdata, m_wdata);
            if (cyc == 0) chk("rnd_hburst", 32'(hburst), 32'd0);

            if (rsp_due) begin
                rsp_due = 1'b0;
                m_busy  = 1'b0;
            end else if (w >= 0) begin
                pend[w] = 1'b0;
                m_ptr   = w;
                m_owner = w;
                m_busy  = 1'b1;
                m_write = c_write[w];
                m_addr  = c_addr[w];
                m_size  = c_size[w];
                m_wdata = c_wdata[w];
                if (is_legal(m_addr, m_size)) begin
                    addr_ph = 1'b1;
                end else begin
                    rsp_due = 1'b1;
                    m_err   = 1'b1;
                    m_rdata = 32'd0;
                end
            end else if (addr_ph && hready) begin
                addr_ph   = 1'b0;
                data_ph   = 1'b1;
                err_plan  = ($urandom % 4 == 0);
                err_first = 1'b0;
            end else if (data_ph && hready) begin
                data_ph = 1'b0;
                rsp_due = 1'b1;
                m_rdata = m_write ? 32'd0 : hrdata;
                m_err   = hresp;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
